ddr3_test_sequencer: RTL and testbench

Request generator for the DDR3 memory self-test. After controller calibration succeeds, it writes the test pattern to every word of the test region over the Avalon-MM interface, then issues reads of the same region in address order. The returned data is checked downstream against the same pattern. It also throttles reads to a bounded number outstanding and reports sequencing status to the test top level.

---
 rtl/ddr3_test_sequencer_if.sv | 25 ++
 rtl/ddr3_test_sequencer.sv | 155 +++++++++++++++
 tb/tb_ddr3_test_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_test_sequencer_if.sv
// Avalon-MM request/response bundle between the DDR3 self-test sequencer and the memory
// controller. The master side is the sequencer.
interface ddr3_test_sequencer_if #(
  parameter int unsigned WORDS_LOG2 = 24
) ();
  logic                  avl_ready;
  logic                  avl_rdata_valid;
  logic                  avl_burstbegin;
  logic                  avl_write_req;
  logic                  avl_read_req;
  logic [WORDS_LOG2-1:0] avl_addr;
  logic [63:0]           avl_wdata;
  logic [7:0]            avl_be;
  logic [2:0]            avl_size;

  modport master (
    input  avl_ready, avl_rdata_valid,
    output avl_burstbegin, avl_write_req, avl_read_req, avl_addr, avl_wdata, avl_be, avl_size
  );

  modport slave (
    output avl_ready, avl_rdata_valid,
    input  avl_burstbegin, avl_write_req, avl_read_req, avl_addr, avl_wdata, avl_be, avl_size
  );
endinterface

// File: rtl/ddr3_test_sequencer.sv
// DDR3 self-test request generator: after calibration, writes the pattern to every word of
// the test region, then reads it back in address order with a bounded read window.
module ddr3_test_sequencer #(
  parameter int unsigned WORDS_LOG2      = 24,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ddr3_init_done,
  input  logic                  ddr3_cal_success,
  input  logic                  ddr3_cal_fail,
  ddr3_test_sequencer_if.master avl,
  output logic                  writes_done,
  output logic                  reads_done,
  output logic                  error
);

  localparam logic [63:0] Pattern = 64'hdeadfadebabebeef;
  localparam logic [7:0]  MaxOut  = 8'(MAX_OUTSTANDING);
  localparam int unsigned CntW    = WORDS_LOG2 + 1;

  typedef enum logic [2:0] {StWaitInit, StWrite, StRead, StDone, StError} state_e;

  state_e                r_state, w_state_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d, w_cnt_inc, w_cnt_next;
  logic [7:0]            r_outst, w_outst_d, w_outst_next;
  logic                  r_write_req, w_write_req_d;
  logic                  r_read_req, w_read_req_d;
  logic                  r_burst, w_burst_d;
  logic [WORDS_LOG2-1:0] r_addr, w_addr_d;
  logic [63:0]           r_wdata, w_wdata_d;
  logic                  r_writes_done, w_writes_done_d;
  logic                  r_reads_done, w_reads_done_d;
  logic                  r_error, w_error_d;
  logic                  w_wr_acc, w_rd_acc, w_rvalid, w_last_write, w_reads_fin, w_cal_fail;

  assign w_wr_acc     = r_write_req & avl.avl_ready;
  assign w_rd_acc     = r_read_req & avl.avl_ready;
  assign w_rvalid     = avl.avl_rdata_valid & (r_state == StRead);
  assign w_cnt_inc    = r_cnt + CntW'(1);
  assign w_cnt_next   = (w_wr_acc | w_rd_acc) ? w_cnt_inc : r_cnt;
  assign w_last_write = w_wr_acc & w_cnt_inc[WORDS_LOG2];
  assign w_reads_fin  = (r_state == StRead) & w_cnt_next[WORDS_LOG2] & (w_outst_next == '0);
  assign w_cal_fail   = ddr3_init_done & ~ddr3_cal_success & ddr3_cal_fail;

  // Accept and return in the same cycle cancel; the count saturates at zero.
  always_comb begin
    w_outst_next = r_outst;
    if (w_rd_acc && !w_rvalid) begin
      w_outst_next = r_outst + 8'd1;
    end else if (!w_rd_acc && w_rvalid && (r_outst != '0)) begin
      w_outst_next = r_outst - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StWaitInit;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StWaitInit: begin
        if (ddr3_init_done && ddr3_cal_success) begin
          w_state_d = StWrite;
        end else if (w_cal_fail) begin
          w_state_d = StError;
        end
      end
      StWrite: if (w_last_write) w_state_d = StRead;
      StRead:  if (w_reads_fin) w_state_d = StDone;
      default: w_state_d = r_state;
    endcase
  end

  // Next values of every registered output; an unaccepted request is re-presented unchanged.
  always_comb begin
    w_cnt_d         = r_cnt;
    w_outst_d       = r_outst;
    w_write_req_d   = 1'b0;
    w_read_req_d    = 1'b0;
    w_addr_d        = r_addr;
    w_wdata_d       = r_wdata;
    w_writes_done_d = r_writes_done;
    w_reads_done_d  = r_reads_done;
    w_error_d       = r_error;
    case (r_state)
      StWaitInit: if (w_cal_fail) w_error_d = 1'b1;
      StWrite: begin
        if (w_last_write) begin
          w_cnt_d         = '0;
          w_addr_d        = '0;
          w_writes_done_d = 1'b1;
        end else begin
          w_cnt_d       = w_cnt_next;
          w_write_req_d = 1'b1;
          w_addr_d      = w_cnt_next[WORDS_LOG2-1:0];
          w_wdata_d     = Pattern ^ 64'(w_cnt_next[WORDS_LOG2-1:0]);
        end
      end
      StRead: begin
        w_cnt_d      = w_cnt_next;
        w_outst_d    = w_outst_next;
        w_addr_d     = w_cnt_next[WORDS_LOG2-1:0];
        w_read_req_d = (r_read_req & ~avl.avl_ready) |
                       (~w_cnt_next[WORDS_LOG2] & (w_outst_next < MaxOut));
        if (w_reads_fin) w_reads_done_d = 1'b1;
      end
      default: ;
    endcase
    w_burst_d = w_write_req_d | w_read_req_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_outst       <= '0;
      r_write_req   <= 1'b0;
      r_read_req    <= 1'b0;
      r_burst       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_writes_done <= 1'b0;
      r_reads_done  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_d;
      r_outst       <= w_outst_d;
      r_write_req   <= w_write_req_d;
      r_read_req    <= w_read_req_d;
      r_burst       <= w_burst_d;
      r_addr        <= w_addr_d;
      r_wdata       <= w_wdata_d;
      r_writes_done <= w_writes_done_d;
      r_reads_done  <= w_reads_done_d;
      r_error       <= w_error_d;
    end
  end

  assign avl.avl_burstbegin = r_burst;
  assign avl.avl_write_req  = r_write_req;
  assign avl.avl_read_req   = r_read_req;
  assign avl.avl_addr       = r_addr;
  assign avl.avl_wdata      = r_wdata;
  assign avl.avl_be         = 8'hff;
  assign avl.avl_size       = 3'h1;
  assign writes_done        = r_writes_done;
  assign reads_done         = r_reads_done;
  assign error              = r_error;

endmodule

// File: tb/tb_ddr3_test_sequencer.sv
// Directed bench for ddr3_test_sequencer: write-phase vector tables plus hand-written
// read-window, calibration-failure and reset sequences, with a fixed-latency read model.
module tb_ddr3_test_sequencer;
  localparam int unsigned WordsLog2 = 3;
  localparam int unsigned MaxOut    = 2;

  typedef struct {
    logic        ready;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [63:0] wdata;
    logic        wdone;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic init_done, cal_success, cal_fail;
  logic writes_done, reads_done, error;
  int   checks = 0;
  int   errors = 0;
  vec_t vec [25];

  int       exp_addr, outst, max_outst, nvalid, cyc;
  logic [3:0] pipe;
  logic     acc;

  ddr3_test_sequencer_if #(.WORDS_LOG2(WordsLog2)) avl_if ();

  ddr3_test_sequencer #(
    .WORDS_LOG2     (WordsLog2),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ddr3_init_done  (init_done),
    .ddr3_cal_success(cal_success),
    .ddr3_cal_fail   (cal_fail),
    .avl             (avl_if),
    .writes_done     (writes_done),
    .reads_done      (reads_done),
    .error           (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string name);
    check({name, "_wr"},    64'(avl_if.avl_write_req),  64'd0);
    check({name, "_rd"},    64'(avl_if.avl_read_req),   64'd0);
    check({name, "_burst"}, 64'(avl_if.avl_burstbegin), 64'd0);
    check({name, "_addr"},  64'(avl_if.avl_addr),       64'd0);
    check({name, "_wdata"}, avl_if.avl_wdata,           64'd0);
    check({name, "_wdone"}, 64'(writes_done),           64'd0);
    check({name, "_rdone"}, 64'(reads_done),            64'd0);
    check({name, "_err"},   64'(error),                 64'd0);
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    #1;
    check_cleared(name);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic idle(input int n, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen = seen | avl_if.avl_write_req | avl_if.avl_read_req | avl_if.avl_burstbegin;
      next_cycle();
    end
    check(name, 64'(seen), 64'd0);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      avl_if.avl_ready = vec[i].ready;
      @(negedge clk);
      check($sformatf("v%0d_wr", i), 64'(avl_if.avl_write_req), 64'(vec[i].wr));
      check($sformatf("v%0d_rd", i), 64'(avl_if.avl_read_req), 64'(vec[i].rd));
      check($sformatf("v%0d_burst", i), 64'(avl_if.avl_burstbegin), 64'(vec[i].wr | vec[i].rd));
      check($sformatf("v%0d_wdone", i), 64'(writes_done), 64'(vec[i].wdone));
      if (vec[i].wr) begin
        check($sformatf("v%0d_addr", i), 64'(avl_if.avl_addr), 64'(vec[i].addr));
        check($sformatf("v%0d_wdata", i), avl_if.avl_wdata, vec[i].wdata);
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Run 1 (ready always 1): N+1 idle, writes 0..7, then the one-cycle request gap.
    vec[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 64'h0, 1'b0};
    vec[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 64'hdeadfadebabebeef, 1'b0};
    vec[2]  = '{1'b1, 1'b1, 1'b0, 3'd1, 64'hdeadfadebabebeee, 1'b0};
    vec[3]  = '{1'b1, 1'b1, 1'b0, 3'd2, 64'hdeadfadebabebeed, 1'b0};
    vec[4]  = '{1'b1, 1'b1, 1'b0, 3'd3, 64'hdeadfadebabebeec, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 1'b0, 3'd4, 64'hdeadfadebabebeeb, 1'b0};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 3'd5, 64'hdeadfadebabebeea, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 1'b0, 3'd6, 64'hdeadfadebabebee9, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 1'b0, 3'd7, 64'hdeadfadebabebee8, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 64'h0, 1'b1};
    // Run 2: same walk with five cycles of backpressure on address 3.
    vec[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 1'b0};
    vec[11] = '{1'b1, 1'b1, 1'b0, 3'd0, 64'hdeadfadebabebeef, 1'b0};
    vec[12] = '{1'b1, 1'b1, 1'b0, 3'd1, 64'hdeadfadebabebeee, 1'b0};
    vec[13] = '{1'b1, 1'b1, 1'b0, 3'd2, 64'hdeadfadebabebeed, 1'b0};
    for (int i = 14; i <= 18; i++) vec[i] = '{1'b0, 1'b1, 1'b0, 3'd3, 64'hdeadfadebabebeec, 1'b0};
    vec[19] = '{1'b1, 1'b1, 1'b0, 3'd3, 64'hdeadfadebabebeec, 1'b0};
    vec[20] = '{1'b1, 1'b1, 1'b0, 3'd4, 64'hdeadfadebabebeeb, 1'b0};
    vec[21] = '{1'b1, 1'b1, 1'b0, 3'd5, 64'hdeadfadebabebeea, 1'b0};
    vec[22] = '{1'b1, 1'b1, 1'b0, 3'd6, 64'hdeadfadebabebee9, 1'b0};
    vec[23] = '{1'b1, 1'b1, 1'b0, 3'd7, 64'hdeadfadebabebee8, 1'b0};
    vec[24] = '{1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 1'b1};

    reset_n                = 1'b0;
    init_done              = 1'b0;
    cal_success            = 1'b0;
    cal_fail               = 1'b0;
    avl_if.avl_ready       = 1'b0;
    avl_if.avl_rdata_valid = 1'b0;
    #2;
    check_cleared("rst");
    check("rst_be", 64'(avl_if.avl_be), 64'hff);
    check("rst_size", 64'(avl_if.avl_size), 64'h1);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    // Calibration flags are ignored until init_done.
    cal_success = 1'b1;
    idle(4, "no_req_without_init");

    cal_success = 1'b0;
    cal_fail    = 1'b1;
    init_done   = 1'b1;
    @(negedge clk);
    check("err_before", 64'(error), 64'd0);
    next_cycle();
    @(negedge clk);
    check("err_next_cycle", 64'(error), 64'd1);
    next_cycle();
    idle(6, "no_req_after_fail");
    check("err_sticky", 64'(error), 64'd1);

    init_done = 1'b0;
    cal_fail  = 1'b0;
    do_reset("rst1");

    // Run 1: full-rate writes, then reads against a 4-cycle-latency memory model.
    repeat (4) next_cycle();
    init_done   = 1'b1;
    cal_success = 1'b1;
    next_cycle();
    apply_vecs(0, 9);

    exp_addr         = 0;
    outst            = 0;
    max_outst        = 0;
    nvalid           = 0;
    cyc              = 0;
    pipe             = 4'b0;
    avl_if.avl_ready = 1'b1;
    while (!reads_done && cyc < 200) begin
      @(negedge clk);
      acc = avl_if.avl_read_req & avl_if.avl_ready;
      if (avl_if.avl_rdata_valid) begin
        nvalid++;
        outst--;
      end
      if (acc) begin
        check("rd_addr_order", 64'(avl_if.avl_addr), 64'(exp_addr));
        exp_addr++;
        outst++;
      end
      if (outst > max_outst) max_outst = outst;
      next_cycle();
      pipe                   = {pipe[2:0], acc};
      avl_if.avl_rdata_valid = pipe[3];
      cyc++;
    end
    avl_if.avl_rdata_valid = 1'b0;
    check("reads_done_set", 64'(reads_done), 64'd1);
    check("rdone_after_8_valid", 64'(nvalid), 64'd8);
    check("reads_issued", 64'(exp_addr), 64'd8);
    check("max_outstanding", 64'(max_outst), 64'd2);
    idle(5, "done_idle");
    check("done_wdone", 64'(writes_done), 64'd1);
    check("done_rdone", 64'(reads_done), 64'd1);

    init_done   = 1'b0;
    cal_success = 1'b0;
    do_reset("rst2");

    // Run 2: both calibration flags high (success wins), writes under backpressure.
    next_cycle();
    init_done   = 1'b1;
    cal_success = 1'b1;
    cal_fail    = 1'b1;
    next_cycle();
    apply_vecs(10, 24);
    check("both_flags_no_err", 64'(error), 64'd0);

    avl_if.avl_ready = 1'b1;
    @(negedge clk);
    check("r0_rd", 64'(avl_if.avl_read_req), 64'd1);
    check("r0_addr", 64'(avl_if.avl_addr), 64'd0);
    next_cycle();
    avl_if.avl_rdata_valid = 1'b1;
    @(negedge clk);
    check("r1_rd", 64'(avl_if.avl_read_req), 64'd1);
    check("r1_addr", 64'(avl_if.avl_addr), 64'd1);
    next_cycle();
    avl_if.avl_rdata_valid = 1'b0;
    @(negedge clk);
    check("simul_keeps_one", 64'(avl_if.avl_read_req), 64'd1);
    check("r2_addr", 64'(avl_if.avl_addr), 64'd2);
    next_cycle();
    avl_if.avl_ready = 1'b0;
    @(negedge clk);
    check("window_full_no_req", 64'(avl_if.avl_read_req), 64'd0);
    check("r3_wdone", 64'(writes_done), 64'd1);
    next_cycle();

    // Reset while two reads are outstanding, then recalibrate.
    init_done   = 1'b0;
    cal_success = 1'b0;
    cal_fail    = 1'b0;
    #2;
    do_reset("rst_mid_read");
    repeat (2) next_cycle();
    init_done   = 1'b1;
    cal_success = 1'b1;
    next_cycle();
    apply_vecs(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
